opt_resp_capture: RTL and testbench
===================================

Name: opt_resp_capture

Overview:
- Downstream response-capture stage for the small combinational optimization blocks (single-bit `y` outputs).
- On `start`, samples the DUT output `y_in` for a fixed window of `WIN` clock cycles. Over that window it produces:
  - the count of ones,
  - the count of transitions,
  - a 16-bit LFSR signature.
- Results are presented on a valid/ready handshake, so the post-synthesis netlist and the RTL can be compared by signature instead of waveform inspection.

Parameters:
- `WIN`, 16: number of `y_in` samples per measurement window; legal range 2..65535.
- `CNT_W`, 8: width of `ones_cnt` and `toggle_cnt`; must satisfy 2^CNT_W > WIN.
- `SEED`, 16'hFFFF: signature register value loaded at window start.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle request to begin a window; honoured only in IDLE.
- `y_in`, in, 1: DUT output under observation.
- `busy`, out, 1: high in RUN and DONE.
- `res_valid`, out, 1: result registers valid (DONE state).
- `res_ready`, in, 1: consumer accepts the result.
- `ones_cnt`, out, CNT_W: number of samples equal to 1.
- `toggle_cnt`, out, CNT_W: number of sample-to-sample changes in the window.
- `signature`, out, 16: LFSR compaction of the sample stream.

Behaviour:
- Reset (`reset_n`=0, asynchronous) forces:
  - state = IDLE;
  - `busy`=0, `res_valid`=0;
  - `ones_cnt`=0, `toggle_cnt`=0, `signature`=0;
  - sample counter = 0, prev-sample flop = 0.
- Reset is effective mid-window or mid-handshake; any partial result is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start`=1 at edge t: go to RUN.
  - At the same edge: clear counts to 0, load `signature`=SEED, clear sample counter.
  - Outputs hold the previous result until then.
- RUN:
  - Each cycle, sample `y_in`. The first sample is taken at edge t+1.
  - `ones_cnt` += sample.
  - Toggle rule: `toggle_cnt` += (sample != prev) for every sample except the first; the first sample only loads prev.
  - `signature` update: `{signature[14:0], fb}`, where fb = `signature[15]` ^ `signature[13]` ^ `signature[12]` ^ `signature[10]` ^ sample.
  - After the WIN-th sample (edge t+WIN), go to DONE.
- DONE:
  - `res_valid`=1; all result outputs stable.
  - On `res_valid` && `res_ready`: go to IDLE next edge. Results remain readable but `res_valid`=0.
- `start` outside IDLE is ignored, including the handshake-completion cycle; no queuing.
- `res_ready` outside DONE is ignored.
- Latency: `start` at edge t gives `res_valid` high after edge t+WIN. The minimum start-to-start period is WIN+2 cycles.
- Counters cannot overflow given the CNT_W constraint. This is checked by an elaboration-time error if 2^CNT_W <= WIN.

Optional Feature:
- Macro: `OPT_RESP_SYNC_EN`.
- Defined:
  - `y_in` passes through a 2-flop synchronizer, reset to 0, before sampling.
  - RUN still takes exactly WIN samples, but they are `y_in` delayed by 2 cycles.
  - Start-to-valid latency is unchanged; the window is shifted.
- Not defined: `y_in` is sampled directly, with no extra flops.

Decomposition:
- Package/header `opt_resp_pkg`:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - `SIG_TAPS` constant (bits 15, 13, 12, 10);
  - default `SEED`.
- One sub-module: `opt_resp_lfsr16`, 16-bit serial-input LFSR.
  - Inputs: `clk`, `reset_n`, `load`, `seed`, `en`, `din`.
  - Output: `q`.
  - Instantiated once for `signature`.
- Counters, toggle logic and FSM stay in the top module.

Test Plan:
1. `y_in` held 1, WIN=16, `start` pulse → `res_valid` exactly 17 cycles after `start`; `ones_cnt`=16; `toggle_cnt`=0; `signature` matches the bench model.
2. `y_in` alternating 0,1,0,... starting 0 → `ones_cnt`=8; `toggle_cnt`=15; `signature` ≠ the all-ones-run value.
3. `res_ready` held 0 for 5 cycles in DONE, with a `start` pulse during DONE → `res_valid` and all results stable throughout; `start` ignored; IDLE after `res_ready`=1.
4. `reset_n` driven low at sample 7 of a RUN → immediate `busy`=0, `res_valid`=0, counts=0, `signature`=0; a new `start` then gives a clean full window.
5. DUT with `a`/`b`/`c` toggled at periods 10/55/75 cycles, WIN=300 (CNT_W=9) → `ones_cnt`, `toggle_cnt` and `signature` are equal for RTL and post-synthesis netlist runs.
6. With `OPT_RESP_SYNC_EN` defined: `y_in`=0 for one cycle after `start`, then 1 → `ones_cnt`=WIN-2 (first two samples are synchronizer reset zeros) and `toggle_cnt`=1.

Source files
------------

// File: rtl/opt_resp_pkg.sv
// Shared definitions for the opt_resp capture stage: FSM encoding,
// signature LFSR taps and the default signature seed.
package opt_resp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Feedback taps of the signature register: bits 15, 13, 12 and 10.
    localparam logic [15:0] SIG_TAPS     = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

endpackage

// File: rtl/opt_resp_lfsr16.sv
// 16-bit serial-input LFSR used to compact the sampled response stream
// into a signature; load takes priority over shifting.
module opt_resp_lfsr16
    import opt_resp_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    input  logic        din,
    output logic [15:0] q
);

    logic w_fb;

    assign w_fb = (^(q & SIG_TAPS)) ^ din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= seed;
        end else if (en) begin
            q <= {q[14:0], w_fb};
        end
    end

endmodule

// File: rtl/opt_resp_capture.sv
// Response-capture stage: counts ones and toggles of y_in over WIN samples and
// compacts them into an LFSR signature. Define OPT_RESP_SYNC_EN to add a 2-flop input synchronizer.
module opt_resp_capture
    import opt_resp_pkg::*;
#(
    parameter int unsigned WIN   = 16,
    parameter int unsigned CNT_W = 8,
    parameter logic [15:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             y_in,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] toggle_cnt,
    output logic [15:0]      signature
);

    localparam int unsigned           SCNT_W = (WIN > 2) ? $clog2(WIN) : 1;
    localparam logic [SCNT_W-1:0]     LAST   = SCNT_W'(WIN - 1);

    if ((64'd1 << CNT_W) <= 64'(WIN)) begin : g_cntWidthCheck
        $error("opt_resp_capture: CNT_W too small, 2**CNT_W must exceed WIN");
    end

    state_t            r_state;
    logic [SCNT_W-1:0] r_sampleCnt;
    logic              r_prev;
    logic              w_sample;
    logic              w_load;
    logic              w_en;

`ifdef OPT_RESP_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= y_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = y_in;
`endif

    assign w_load = (r_state == IDLE) && start;
    assign w_en   = (r_state == RUN);

    opt_resp_lfsr16 u_sigLfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .seed    (SEED),
        .en      (w_en),
        .din     (w_sample),
        .q       (signature)
    );

    // The first sample of a window only primes r_prev; toggles count from the second on.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            busy        <= 1'b0;
            res_valid   <= 1'b0;
            ones_cnt    <= '0;
            toggle_cnt  <= '0;
            r_sampleCnt <= '0;
            r_prev      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= RUN;
                        busy        <= 1'b1;
                        ones_cnt    <= '0;
                        toggle_cnt  <= '0;
                        r_sampleCnt <= '0;
                    end
                end
                RUN: begin
                    ones_cnt <= ones_cnt + CNT_W'(w_sample);
                    if (r_sampleCnt != '0) begin
                        toggle_cnt <= toggle_cnt + CNT_W'(w_sample ^ r_prev);
                    end
                    r_prev <= w_sample;
                    if (r_sampleCnt == LAST) begin
                        r_state   <= DONE;
                        res_valid <= 1'b1;
                    end else begin
                        r_sampleCnt <= r_sampleCnt + SCNT_W'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state   <= IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opt_resp_capture.sv
// Scoreboard bench for opt_resp_capture (default build, OPT_RESP_SYNC_EN undefined):
// each window's expected counts/signature are queued at start and popped at res_valid.
module tb_opt_resp_capture;

    localparam int unsigned WIN   = 16;
    localparam int unsigned CNT_W = 8;
    localparam logic [15:0] SEED  = 16'hFFFF;

    typedef struct packed {
        logic [CNT_W-1:0] ones;
        logic [CNT_W-1:0] tog;
        logic [15:0]      sig;
    } result_t;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             y_in;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] toggle_cnt;
    logic [15:0]      signature;

    int      assertCount = 0;
    int      failCount   = 0;
    result_t scoreboard[$];
    logic [15:0] allOnesSig;
    logic [15:0] lastSig;

    opt_resp_capture #(
        .WIN   (WIN),
        .CNT_W (CNT_W),
        .SEED  (SEED)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .y_in       (y_in),
        .busy       (busy),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .ones_cnt   (ones_cnt),
        .toggle_cnt (toggle_cnt),
        .signature  (signature)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Independent reference of the window result from the sample pattern.
    function automatic result_t modelWindow(input logic [WIN-1:0] pat);
        result_t     r;
        logic [15:0] s;
        logic        fb;
        r.ones = '0;
        r.tog  = '0;
        s      = SEED;
        for (int i = 0; i < WIN; i++) begin
            if (pat[i]) r.ones = r.ones + 1'b1;
            if (i > 0 && pat[i] != pat[i-1]) r.tog = r.tog + 1'b1;
            fb = s[15] ^ s[13] ^ s[12] ^ s[10] ^ pat[i];
            s  = {s[14:0], fb};
        end
        r.sig = s;
        return r;
    endfunction

    task automatic applyStimulus(input logic [WIN-1:0] pat, input int readyDelay,
                                 input bit startInDone, input bit readyInRun, input int abortAt);
        result_t exp;
        int      waitCycles;
        scoreboard.push_back(modelWindow(pat));
        @(posedge clk); #1;
        start     = 1'b1;
        res_ready = readyInRun;
        @(posedge clk); #1;
        start = 1'b0;
        y_in  = pat[0];
        checkOutput("busyAtStart", 32'(busy), 32'd1);
        checkOutput("validAtStart", 32'(res_valid), 32'd0);
        for (int i = 0; i < WIN; i++) begin
            @(posedge clk); #1;
            if (abortAt == i + 1) begin
                reset_n = 1'b0;
                #1;
                checkOutput("abortBusy", 32'(busy), 32'd0);
                checkOutput("abortValid", 32'(res_valid), 32'd0);
                checkOutput("abortOnes", 32'(ones_cnt), 32'd0);
                checkOutput("abortToggles", 32'(toggle_cnt), 32'd0);
                checkOutput("abortSig", 32'(signature), 32'd0);
                void'(scoreboard.pop_back());
                #2;
                reset_n   = 1'b1;
                res_ready = 1'b0;
                return;
            end
            if (i + 1 < WIN) y_in = pat[i+1];
            checkOutput("validTiming", 32'(res_valid), 32'(i == WIN - 1));
        end
        waitCycles = 0;
        while (!res_valid && waitCycles < 20) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        if (!res_valid) begin
            checkOutput("validTimeout", 32'd0, 32'd1);
            return;
        end
        exp = scoreboard.pop_front();
        checkOutput("onesCnt", 32'(ones_cnt), 32'(exp.ones));
        checkOutput("toggleCnt", 32'(toggle_cnt), 32'(exp.tog));
        checkOutput("signature", 32'(signature), 32'(exp.sig));
        lastSig = signature;
        if (!readyInRun) begin
            for (int k = 0; k < readyDelay; k++) begin
                start = startInDone && (k == 1);
                @(posedge clk); #1;
                start = 1'b0;
                checkOutput("holdValid", 32'(res_valid), 32'd1);
                checkOutput("holdOnes", 32'(ones_cnt), 32'(exp.ones));
                checkOutput("holdToggles", 32'(toggle_cnt), 32'(exp.tog));
                checkOutput("holdSig", 32'(signature), 32'(exp.sig));
            end
            res_ready = 1'b1;
            start     = startInDone;
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        start     = 1'b0;
        checkOutput("validAfterAccept", 32'(res_valid), 32'd0);
        checkOutput("busyAfterAccept", 32'(busy), 32'd0);
        checkOutput("onesReadable", 32'(ones_cnt), 32'(exp.ones));
        checkOutput("sigReadable", 32'(signature), 32'(exp.sig));
        @(posedge clk); #1;
        checkOutput("idleStaysIdle", 32'(busy), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        y_in      = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstValid", 32'(res_valid), 32'd0);
        checkOutput("rstOnes", 32'(ones_cnt), 32'd0);
        checkOutput("rstToggles", 32'(toggle_cnt), 32'd0);
        checkOutput("rstSig", 32'(signature), 32'd0);
        reset_n = 1'b1;

        $display("[TB] window with y_in held high");
        applyStimulus(16'hFFFF, 0, 1'b0, 1'b0, -1);
        allOnesSig = lastSig;
        checkOutput("allOnesCount", 32'(ones_cnt), 32'd16);
        checkOutput("allOnesToggles", 32'(toggle_cnt), 32'd0);

        $display("[TB] alternating window starting at 0");
        applyStimulus(16'hAAAA, 0, 1'b0, 1'b0, -1);
        checkOutput("altOnes", 32'(ones_cnt), 32'd8);
        checkOutput("altToggles", 32'(toggle_cnt), 32'd15);
        checkOutput("altSigDiffers", 32'(lastSig != allOnesSig), 32'd1);

        $display("[TB] back-pressure with start during DONE");
        applyStimulus(16'h3C5A, 5, 1'b1, 1'b0, -1);

        $display("[TB] reset at sample 7, then a clean window");
        applyStimulus(16'h0F0F, 0, 1'b0, 1'b0, 7);
        applyStimulus(16'h0F0F, 1, 1'b0, 1'b0, -1);

        $display("[TB] random windows");
        for (int n = 0; n < 4; n++) begin
            applyStimulus(16'($urandom), n % 3, 1'b0, (n == 2), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
